pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Controller on the far side of the audio PLL wrapper's reset/locked handshake. Drives the PLL's `rst`, samples its asynchronous `locked`, and qualifies lock over a stability window. Holds the audio-domain reset until lock is stable. Re-initialises the PLL on lock timeout or lock loss, and keeps relock/timeout statistics for debug.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset attempt; must be ≥ 1.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before release; must be ≥ 1.
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before the PLL is reset again.
- `STAT_W`, 8: width of the statistics counters.

Ports:
- `refclk` in 1: single clock, the 50 MHz board reference also fed to the PLL.
- `rst` in 1: reset; synchronous, active-high.
- `locked_in` in 1: PLL `locked`; asynchronous to `refclk`.
- `pll_rst` out 1: drives PLL `rst`; active-high.
- `sys_rst` out 1: active-high reset for the audio clock domains; those domains synchronise it locally.
- `ready` out 1: high while in RUN.
- `lost_lock` out 1: one-cycle pulse when lock drops during RUN.
- `relock_count` out STAT_W: saturating count of lock losses in RUN.
- `timeout_count` out STAT_W: saturating count of WAIT_LOCK timeouts.

## Operation
- `locked_in` passes through a 2-flop synchroniser to produce `lock_s`; no other logic samples `locked_in`.
- A single down/up counter `cnt` is shared by all states and cleared on every state change.

FSM states:
- RESET_PLL:
  - `pll_rst`=1.
  - After RST_PULSE_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_rst`=0.
  - `lock_s`=1: go to STABILIZE.
  - `cnt` reaches LOCK_TIMEOUT_CYCLES−1 with `lock_s`=0: go to RESET_PLL and increment `timeout_count`.
- STABILIZE:
  - `lock_s`=0 in any cycle: go back to WAIT_LOCK; the timeout restarts.
  - LOCK_STABLE_CYCLES consecutive cycles of `lock_s`=1: go to RUN.
- RUN:
  - `sys_rst`=0, `ready`=1.
  - `lock_s`=0: go to RESET_PLL, pulse `lost_lock`, increment `relock_count`.

Output rules:
- `sys_rst`=1 in every state except RUN.
- All outputs are registered.
- Counters saturate at 2^STAT_W−1 and never wrap.
- `rst` overrides everything. Asserting it mid-operation, including in RUN, returns the block to RESET_PLL on the next edge and clears the statistics.
- Simultaneous events: the timeout compare and `lock_s` rising in the same WAIT_LOCK cycle resolve to STABILIZE, with no timeout counted.

## Timing
- Reset values:
  - `pll_rst`=1, `sys_rst`=1.
  - `ready`=0, `lost_lock`=0.
  - `relock_count`=0, `timeout_count`=0.
  - Synchroniser flops = 0, state = RESET_PLL.
- `pll_rst` stays high for exactly RST_PULSE_CYCLES edges after the first edge with `rst`=0, then falls.
- `locked_in` rise to `lock_s` takes 2 edges; STABILIZE is entered on the next edge.
- `sys_rst` falls and `ready` rises on the same edge, LOCK_STABLE_CYCLES edges after STABILIZE entry.
- Total latency from `locked_in` rising to `sys_rst` low = 3 + LOCK_STABLE_CYCLES edges.
- Lock loss in RUN: `lock_s` falls 2 edges after `locked_in` falls. On the next edge `sys_rst`=1, `ready`=0, `pll_rst`=1, and `lost_lock`=1 for exactly that cycle.

## Configuration
- `PLL_SUP_STATUS_EN` defined: `relock_count`, `timeout_count` and `lost_lock` are implemented as described.
- `PLL_SUP_STATUS_EN` undefined:
  - Those three outputs are tied to 0 and their registers are removed.
  - FSM, `pll_rst`, `sys_rst` and `ready` behaviour is unchanged.

## Structure
- Package `pll_sup_pkg` holds:
  - the state enum `pll_sup_state_t` {RESET_PLL, WAIT_LOCK, STABILIZE, RUN};
  - default parameter constants;
  - the counter-width function (clog2 of the largest cycle parameter).
- Sub-module `pll_sup_sync`: parameterless 2-flop bit synchroniser. Its flops are reset synchronously to 0 and carry the synchroniser attribute.
- The top module holds the FSM, the shared counter and the statistics.

## Test plan
Run with RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, STAT_W=2, `PLL_SUP_STATUS_EN` defined, unless noted.
- Release `rst`, raise `locked_in` 10 cycles later → `pll_rst` high exactly 4 cycles; `sys_rst` falls and `ready` rises 11 cycles after the `locked_in` rise.
- Keep `locked_in`=0 → `pll_rst` re-pulses every 36 cycles (4 + 32); `timeout_count` goes 1, 2, 3 and holds at 3 (saturation).
- In STABILIZE, glitch `locked_in` low for 1 cycle at stable count 5 → state returns to WAIT_LOCK; `sys_rst` is held high; a full 8-cycle window restarts after lock returns.
- In RUN, drop `locked_in` → `lost_lock` pulses once, 3 edges after the drop; `relock_count`=1; `pll_rst` high 4 cycles; normal re-lock follows.
- Assert `rst` for 1 cycle during RUN → next edge: `sys_rst`=1, `pll_rst`=1, counters 0.
- Rebuild without `PLL_SUP_STATUS_EN` and repeat the lock-loss scenario → `lost_lock`, `relock_count` and `timeout_count` stay 0; FSM timing is identical.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types, default parameters and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;

    localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int unsigned DEF_STAT_W              = 8;

    // Width of the shared cycle counter: it only ever needs to reach (largest cycle parameter - 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Two-flop synchroniser for a single asynchronous bit.
module pll_sup_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    // Metastability chain, cleared by the block reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, qualifies lock over a
// stability window and holds the audio-domain reset until lock is stable.
// Optional macro PLL_SUP_STATUS_EN enables lost_lock / relock_count / timeout_count.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned STAT_W              = DEF_STAT_W
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              locked_in,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic              lost_lock,
    output logic [STAT_W-1:0] relock_count,
    output logic [STAT_W-1:0] timeout_count
);

    localparam int unsigned CNT_W =
        cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    pll_sup_state_t   state;
    pll_sup_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lock_s;

    pll_sup_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked_in),
        .q   (lock_s)
    );

    // Next state and shared counter; a lock sighting in WAIT_LOCK beats the timeout.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        unique case (state)
            RESET_PLL: begin
                if (cnt == PULSE_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                     state_nxt = STABILIZE;
                else if (cnt == TIMEOUT_LAST)   state_nxt = RESET_PLL;
            end
            STABILIZE: begin
                if (!lock_s)                    state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST)    state_nxt = RUN;
            end
            RUN: begin
                cnt_nxt = cnt;
                if (!lock_s) state_nxt = RESET_PLL;
            end
            default: state_nxt = RESET_PLL;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // State, counter and registered control outputs decoded from the next state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state   <= RESET_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pll_rst <= (state_nxt == RESET_PLL);
            sys_rst <= (state_nxt != RUN);
            ready   <= (state_nxt == RUN);
        end
    end

`ifdef PLL_SUP_STATUS_EN
    logic timeout_ev_c;
    logic lost_ev_c;

    assign timeout_ev_c = (state == WAIT_LOCK) && (state_nxt == RESET_PLL);
    assign lost_ev_c    = (state == RUN)       && (state_nxt == RESET_PLL);

    // Debug statistics: lost-lock pulse and saturating event counters.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lost_lock     <= 1'b0;
            relock_count  <= '0;
            timeout_count <= '0;
        end else begin
            lost_lock <= lost_ev_c;
            if (lost_ev_c && (relock_count != '1))
                relock_count <= relock_count + STAT_W'(1);
            if (timeout_ev_c && (timeout_count != '1))
                timeout_count <= timeout_count + STAT_W'(1);
        end
    end
`else
    assign lost_lock     = 1'b0;
    assign relock_count  = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a timestamp-based reference model
// predicts outputs for every edge; a monitor compares them half a cycle later.
module tb_pll_lock_supervisor;

    localparam int unsigned P_PULSE   = 4;
    localparam int unsigned P_STABLE  = 8;
    localparam int unsigned P_TIMEOUT = 32;
    localparam int unsigned P_STAT_W  = 2;
    localparam int          STAT_MAX  = (1 << P_STAT_W) - 1;

    localparam int PH_PULSE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_RUN   = 3;

    logic                refclk = 1'b0;
    logic                rst = 1'b1;
    logic                locked_in = 1'b0;
    logic                pll_rst;
    logic                sys_rst;
    logic                ready;
    logic                lost_lock;
    logic [P_STAT_W-1:0] relock_count;
    logic [P_STAT_W-1:0] timeout_count;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (P_PULSE),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
        .STAT_W              (P_STAT_W)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .locked_in     (locked_in),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .lost_lock     (lost_lock),
        .relock_count  (relock_count),
        .timeout_count (timeout_count)
    );

    always #10 refclk = ~refclk;

    // ---------------- reference model ----------------
    // Phases are tracked by the edge on which they began; durations are
    // measured as elapsed edges rather than with a per-state counter.
    int  edge_n    = 0;
    int  m_phase   = PH_PULSE;
    int  m_start   = 0;
    bit  m_d1      = 1'b0;
    bit  m_d2      = 1'b0;
    bit  m_lost    = 1'b0;
    int  m_relock  = 0;
    int  m_timeout = 0;
    logic [7:0] exp_q[$];

    always @(posedge refclk) begin
        bit seen;
        bit st_en;
        logic [7:0] e;
        edge_n++;
        seen   = m_d2;
        m_lost = 1'b0;
        if (rst) begin
            m_phase = PH_PULSE; m_start = edge_n;
            m_relock = 0; m_timeout = 0;
            m_d1 = 1'b0; m_d2 = 1'b0;
        end else begin
            case (m_phase)
                PH_PULSE: if (edge_n - m_start == P_PULSE) begin
                    m_phase = PH_WAIT; m_start = edge_n;
                end
                PH_WAIT: if (seen) begin
                    m_phase = PH_STAB; m_start = edge_n;
                end else if (edge_n - m_start == P_TIMEOUT) begin
                    m_phase = PH_PULSE; m_start = edge_n;
                    if (m_timeout < STAT_MAX) m_timeout++;
                end
                PH_STAB: if (!seen) begin
                    m_phase = PH_WAIT; m_start = edge_n;
                end else if (edge_n - m_start == P_STABLE) begin
                    m_phase = PH_RUN; m_start = edge_n;
                end
                default: if (!seen) begin
                    m_phase = PH_PULSE; m_start = edge_n;
                    m_lost = 1'b1;
                    if (m_relock < STAT_MAX) m_relock++;
                end
            endcase
            m_d2 = m_d1;
            m_d1 = locked_in;
        end
`ifdef PLL_SUP_STATUS_EN
        st_en = 1'b1;
`else
        st_en = 1'b0;
`endif
        e[7]   = (m_phase == PH_PULSE);
        e[6]   = (m_phase != PH_RUN);
        e[5]   = (m_phase == PH_RUN);
        e[4]   = st_en & m_lost;
        e[3:2] = st_en ? 2'(m_relock) : 2'b00;
        e[1:0] = st_en ? 2'(m_timeout) : 2'b00;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge refclk) begin
        logic [7:0] e;
        logic [7:0] a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {pll_rst, sys_rst, ready, lost_lock, relock_count, timeout_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs edge=%0d {pll_rst,sys_rst,ready,lost_lock,relock,timeout} got=%b want=%b",
                         edge_n, a, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Raise locked_in and count edges until sys_rst falls (bounded).
    task automatic measure_release(input string name);
        int lat;
        lat = 0;
        locked_in = 1'b1;
        while (sys_rst !== 1'b0 && lat < 200) begin
            @(posedge refclk); #1; lat++;
        end
        check_val(name, lat, 3 + P_STABLE);
        @(negedge refclk);
    endtask

    initial begin
        int hi;
        int lat;
        int st_exp;
        // reset and initial release
        tick(3);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (pll_rst === 1'b1) hi++;
            @(negedge refclk);
        end
        check_val("pll_rst_pulse_len", hi, P_PULSE);
        measure_release("lock_to_release_latency");
        tick(5);

        // lock loss in RUN, then normal re-lock
        locked_in = 1'b0;
        lat = 0;
        while (pll_rst !== 1'b1 && lat < 50) begin
            @(posedge refclk); #1; lat++;
        end
        check_val("lost_lock_edges_after_drop", lat, 3);
        @(negedge refclk);
        tick(10);
        measure_release("relock_latency");
        tick(4);

        // one-cycle reset while in RUN
        rst = 1'b1;
        @(posedge refclk); #1;
        check_val("rst_in_run_state", {sys_rst, pll_rst, ready, relock_count, timeout_count}, 8'b11000000 >> 1);
        @(negedge refclk);
        rst = 1'b0;
        locked_in = 1'b0;

        // timeouts with no lock: saturation of timeout_count
        tick(P_PULSE + 5 * (P_PULSE + P_TIMEOUT));
`ifdef PLL_SUP_STATUS_EN
        st_exp = STAT_MAX;
`else
        st_exp = 0;
`endif
        check_val("timeout_count_saturated", int'(timeout_count), st_exp);

        // glitch during STABILIZE at stable count 5
        locked_in = 1'b1;
        tick(6);
        locked_in = 1'b0;
        tick(1);
        measure_release("glitch_restart_latency");
        tick(3);

        // randomized lock behaviour with occasional resets
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 14) == 0) begin
                rst = 1'b1; tick(1); rst = 1'b0;
            end
            locked_in = 1'($urandom_range(0, 3) != 0);
            tick($urandom_range(1, 40));
        end

        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
